// File: rtl/niosge_debug_pkg.sv
// Shared definitions for the on-chip debug memory engine: jdo field map,
// FSM state encodings and control-register bit positions.
package niosge_debug_pkg;

  localparam int ADDR_HI  = 33;
  localparam int ADDR_LO  = 26;
  localparam int CLR_RDY  = 34;
  localparam int CLR_ERR  = 25;
  localparam int SET_GO   = 23;
  localparam int RD_REQ   = 17;
  localparam int WDATA_HI = 34;
  localparam int WDATA_LO = 3;

  localparam int CTRL_RDY = 0;
  localparam int CTRL_ERR = 1;
  localparam int CTRL_GO  = 2;

  typedef enum logic [1:0] {
    J_IDLE = 2'd0,
    J_RD   = 2'd1,
    J_CAP  = 2'd2
  } jtag_state_e;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_RD   = 1'b1
  } cpu_state_e;

endpackage

// File: rtl/niosge_ocimem_ram.sv
// Single-port debug RAM with byte-enabled writes and a registered read port.
// Contents are deliberately not reset so the monitor image survives a reset.
module niosge_ocimem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  i_we,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_q
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    r_q <= r_mem[i_addr];
  end

  assign o_q = r_q;

endmodule

// File: rtl/niosge_cpu_debug_ocimem_ctrl.sv
// Sysclk-side debug memory engine: serves JTAG ocimem commands and an Avalon-MM
// slave for the monitor program, sharing one debug RAM with JTAG priority.
module niosge_cpu_debug_ocimem_ctrl
  import niosge_debug_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int JDO_W  = 38
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W:0]   avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              monitor_go,
  output logic              jtag_busy
);

  jtag_state_e       r_jState, w_jNext;
  cpu_state_e        r_cState, w_cNext;
  logic [ADDR_W-1:0] r_monAReg;
  logic [DATA_W-1:0] r_monDReg;
  logic              r_monReady, r_monError, r_monGo;

  logic              w_jIdle, w_takeA, w_takeN, w_takeB, w_rdStart;
  logic              w_jRamRead, w_jCapture, w_jOwnsRam;
  logic              w_cpuCtrl, w_cpuWr, w_cpuRd, w_cpuRamWr, w_cpuRamRdReq, w_cpuCtrlWr;
  logic [DATA_W-1:0] w_ctrlWord, w_jdoWdata, w_ramQ, w_ramWdata;
  logic [ADDR_W-1:0] w_ramAddr;
  logic [3:0]        w_ramBe;
  logic              w_ramWe;
  logic              w_unusedJdo;

  // Strobes only count while the JTAG engine is idle; one strobe wins if several collide.
  assign w_jIdle    = (r_jState == J_IDLE);
  assign w_takeA    = take_action_ocimem_a & w_jIdle;
  assign w_takeN    = take_no_action_ocimem_a & w_jIdle & ~take_action_ocimem_a;
  assign w_takeB    = take_action_ocimem_b & w_jIdle & ~take_action_ocimem_a
                      & ~take_no_action_ocimem_a;
  assign w_rdStart  = (w_takeA & jdo[RD_REQ]) | w_takeN;
  assign w_jdoWdata = jdo[WDATA_HI:WDATA_LO];
  assign w_unusedJdo = ^{jdo[JDO_W-1:WDATA_HI+1], jdo[WDATA_LO-1:0]};

  always_ff @(posedge clk) begin
    if (reset) r_jState <= J_IDLE;
    else       r_jState <= w_jNext;
  end

  always_comb begin
    w_jNext = r_jState;
    case (r_jState)
      J_IDLE:  if (w_rdStart) w_jNext = J_RD;
      J_RD:    w_jNext = J_CAP;
      J_CAP:   w_jNext = J_IDLE;
      default: w_jNext = J_IDLE;
    endcase
  end

  always_comb begin
    jtag_busy  = (r_jState != J_IDLE);
    w_jRamRead = (r_jState == J_RD);
    w_jCapture = (r_jState == J_CAP);
  end

  assign w_jOwnsRam = w_takeB | w_jRamRead;

  // A simultaneous write wins over a read on the Avalon side.
  assign w_cpuCtrl     = avs_address[ADDR_W];
  assign w_cpuWr       = avs_write;
  assign w_cpuRd       = avs_read & ~avs_write;
  assign w_cpuRamWr    = w_cpuWr & ~w_cpuCtrl & ~w_jOwnsRam;
  assign w_cpuRamRdReq = w_cpuRd & ~w_cpuCtrl;
  assign w_cpuCtrlWr   = w_cpuWr & w_cpuCtrl;

  always_ff @(posedge clk) begin
    if (reset) r_cState <= C_IDLE;
    else       r_cState <= w_cNext;
  end

  always_comb begin
    w_cNext = r_cState;
    case (r_cState)
      C_IDLE:  if (w_cpuRamRdReq && !w_jOwnsRam) w_cNext = C_RD;
      C_RD:    w_cNext = C_IDLE;
      default: w_cNext = C_IDLE;
    endcase
  end

  always_comb begin
    w_ctrlWord           = '0;
    w_ctrlWord[CTRL_RDY] = r_monReady;
    w_ctrlWord[CTRL_ERR] = r_monError;
    w_ctrlWord[CTRL_GO]  = r_monGo;
  end

  // An access caught by reset is released immediately with zero data.
  always_comb begin
    avs_waitrequest = 1'b0;
    avs_readdata    = '0;
    if (!reset) begin
      if (w_cpuWr) begin
        avs_waitrequest = ~w_cpuCtrl & w_jOwnsRam;
      end else if (w_cpuRd) begin
        if (w_cpuCtrl)               avs_readdata    = w_ctrlWord;
        else if (r_cState == C_RD)   avs_readdata    = w_ramQ;
        else                         avs_waitrequest = 1'b1;
      end
    end
  end

  always_comb begin
    w_ramAddr  = avs_address[ADDR_W-1:0];
    w_ramWe    = w_cpuRamWr;
    w_ramBe    = avs_byteenable;
    w_ramWdata = avs_writedata;
    if (w_takeB) begin
      w_ramAddr  = r_monAReg;
      w_ramWe    = 1'b1;
      w_ramBe    = 4'hF;
      w_ramWdata = w_jdoWdata;
    end else if (w_jRamRead) begin
      w_ramAddr  = r_monAReg;
      w_ramWe    = 1'b0;
    end
    w_ramWe = w_ramWe & ~reset;
  end

  niosge_ocimem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_addr  (w_ramAddr),
    .i_we    (w_ramWe),
    .i_be    (w_ramBe),
    .i_wdata (w_ramWdata),
    .o_q     (w_ramQ)
  );

  // Flag sets always beat a clear arriving in the same cycle from the other side.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_monAReg  <= '0;
      r_monDReg  <= '0;
      r_monReady <= 1'b0;
      r_monError <= 1'b0;
      r_monGo    <= 1'b0;
    end else begin
      if (w_takeA)                    r_monAReg <= jdo[ADDR_HI:ADDR_LO];
      else if (w_takeB || w_jCapture) r_monAReg <= r_monAReg + ADDR_W'(1);
      if (w_jCapture) r_monDReg <= w_ramQ;
      r_monReady <= (r_monReady & ~(w_takeA & jdo[CLR_RDY]))
                    | (w_cpuCtrlWr & avs_writedata[CTRL_RDY]);
      r_monError <= (r_monError & ~(w_takeA & jdo[CLR_ERR]))
                    | (w_cpuCtrlWr & avs_writedata[CTRL_ERR]);
      r_monGo    <= (r_monGo & ~(w_cpuCtrlWr & avs_writedata[CTRL_GO]))
                    | (w_takeA & jdo[SET_GO]);
    end
  end

  assign MonDReg       = r_monDReg;
  assign monitor_ready = r_monReady;
  assign monitor_error = r_monError;
  assign monitor_go    = r_monGo;

endmodule

// File: doc/niosge_cpu_debug_ocimem_ctrl.md
Name: niosge_cpu_debug_ocimem_ctrl

Overview:
Sysclk-domain on-chip debug memory engine sitting directly downstream of the debug-slave sysclk stage. It consumes jdo and the take_*_ocimem_* strobes and owns the 256-word debug RAM, the MonAReg address pointer, MonDReg and the monitor handshake flags. It returns MonDReg, monitor_ready and monitor_error to the JTAG capture path. It also exposes an Avalon-MM slave so the CPU's debug monitor program can reach the same RAM and control register.

Parameters:
ADDR_W, 8, debug RAM word-address width (256 words)
DATA_W, 32, RAM and MonDReg data width
JDO_W, 38, width of the jdo command word

Ports:
clk  in  1  system clock, every register on rising edge
reset  in  1  synchronous, active-high reset
jdo  in  JDO_W  command/data word, valid while a strobe is high
take_action_ocimem_a  in  1  one-cycle strobe: address/control command
take_no_action_ocimem_a  in  1  one-cycle strobe: streaming read at MonAReg
take_action_ocimem_b  in  1  one-cycle strobe: write jdo[34:3] at MonAReg
avs_address  in  ADDR_W+1  bit ADDR_W=1 selects control register, else RAM word
avs_read  in  1  CPU read request
avs_write  in  1  CPU write request
avs_writedata  in  DATA_W  CPU write data
avs_byteenable  in  4  CPU byte enables, RAM writes only
avs_readdata  out  DATA_W  valid in the cycle avs_read is accepted (waitrequest low)
avs_waitrequest  out  1  stall CPU access
MonDReg  out  DATA_W  last JTAG-read RAM word
monitor_ready  out  1  monitor finished last request
monitor_error  out  1  monitor reported error
monitor_go  out  1  JTAG requests monitor execution
jtag_busy  out  1  JTAG FSM not in J_IDLE

Behaviour:
- Reset values: every output is 0; MonAReg = 0; both FSMs idle. RAM contents are not cleared.
- take_action_ocimem_a decode, all fields in the same cycle:
  - MonAReg <= jdo[33:26]
  - jdo[34]=1 clears monitor_ready
  - jdo[25]=1 clears monitor_error
  - jdo[23]=1 sets monitor_go
  - jdo[17]=1 starts a read at the new address; otherwise there is no RAM access.
- take_no_action_ocimem_a starts a read at the current MonAReg.
- take_action_ocimem_b writes jdo[34:3] (all bytes) at MonAReg in the same cycle, then MonAReg++.
- JTAG FSM:
  - J_IDLE: on a read start -> J_RD (RAM address presented).
  - J_RD -> J_CAP. J_CAP: MonDReg <= RAM q; MonAReg++; -> J_IDLE.
  - Read latency: MonDReg is updated 2 cycles after the strobe.
- A strobe arriving while jtag_busy=1 is ignored entirely: no field takes effect.
- MonAReg increments modulo 2^ADDR_W (0xFF -> 0x00).
- RAM arbitration: the JTAG side wins any cycle it drives the RAM (write cycle, J_RD). A CPU RAM access in such a cycle sees avs_waitrequest=1.
- CPU RAM read:
  - C_IDLE: address presented, waitrequest=1 -> C_RD.
  - C_RD: waitrequest=0, readdata = RAM q -> C_IDLE.
  - If JTAG owns the RAM in the C_IDLE cycle, remain in C_IDLE.
- CPU RAM write: completes in one cycle (waitrequest=0) unless JTAG owns the RAM that cycle; byteenable masks bytes.
- CPU control register:
  - Read: zero-wait, returns {29'b0, monitor_go, monitor_error, monitor_ready}.
  - Write: bit0=1 sets monitor_ready, bit1=1 sets monitor_error, bit2=1 clears monitor_go; zero-wait.
- Simultaneous JTAG clear and CPU set of the same flag: the set wins.
- Simultaneous JTAG set of monitor_go and CPU clear: the set wins.
- avs_read and avs_write both high: the write is performed and the read is ignored.
- Reset asserted mid-read: FSMs return to idle at once; MonDReg does not update; the aborted CPU access sees waitrequest=0 with readdata=0.

Decomposition:
- Shared package niosge_debug_pkg holds:
  - jdo field bit positions (ADDR_HI/LO=33/26, CLR_RDY=34, CLR_ERR=25, SET_GO=23, RD_REQ=17, WDATA_HI/LO=34/3)
  - JTAG and CPU FSM state enums
  - control-register bit indices
- One sub-module: niosge_ocimem_ram. It is a single-port, 1-cycle-read, byte-enabled 2^ADDR_W x DATA_W synchronous RAM with no reset.

Test Plan:
- Reset, then take_action_ocimem_a with jdo[33:26]=0x10 and jdo[17]=0 -> MonAReg=0x10, no RAM access, MonDReg=0. Then three take_action_ocimem_b with data 0xA, 0xB, 0xC -> RAM[0x10..0x12] hold these values, MonAReg=0x13.
- take_action_ocimem_a with addr 0x10 and jdo[17]=1, then two take_no_action_ocimem_a spaced 4 cycles -> MonDReg=0xA two cycles after the first strobe, then 0xB, then 0xC.
- Write at MonAReg=0xFF -> MonAReg wraps to 0x00. A read strobe presented while jtag_busy=1 -> strobe ignored, MonAReg unchanged.
- CPU reads RAM 0x11 in the same cycle as a JTAG write strobe -> waitrequest high for 2 cycles, readdata=0xB when waitrequest drops.
- CPU writes ctrl 0x1 in the same cycle as JTAG ocimem_a with jdo[34]=1 -> monitor_ready=1. Then JTAG jdo[23]=1 -> monitor_go=1; CPU ctrl read returns 0x5.
- Assert reset during J_RD -> all outputs 0, jtag_busy=0 the next cycle, RAM[0x10] still 0xA.
